// File: rtl/rega_pkg.sv
// Shared definitions for the irrigation sequencer: FSM state codes, soil-moisture codes
// and sprinkler/drip mux select codes.
package rega_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIP  = 3'd1,
    ST_SPRAY = 3'd2,
    ST_COOL  = 3'd3,
    ST_FILL  = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  localparam logic [1:0] UMID_VDRY  = 2'b00;
  localparam logic [1:0] UMID_DRY   = 2'b01;
  localparam logic [1:0] UMID_MOIST = 2'b10;
  localparam logic [1:0] UMID_WET   = 2'b11;

  localparam logic MODE_DRIP  = 1'b0;
  localparam logic MODE_SPRAY = 1'b1;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a stability counter: the output follows the synced
// input only after DEB_CYCLES consecutive cycles of disagreement.
module sensor_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic d_out
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1_q, sync2_q, out_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= d_in;
      sync2_q <= sync1_q;
      // Any cycle of agreement restarts the stability count.
      if (sync2_q == out_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        out_q <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign d_out = out_q;

endmodule

// File: rtl/irrigation_sequencer.sv
// Moore FSM choosing drip/sprinkler irrigation, tank refill and fault lockout from
// debounced sensors; drives the method-mux select and the valve/pump enables.
module irrigation_sequencer
  import rega_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int DEB_CYCLES   = 4,
  parameter int DRIP_CYCLES  = 20,
  parameter int SPRAY_CYCLES = 10,
  parameter int COOL_CYCLES  = 8,
  parameter int FILL_MAX     = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] umid,
  input  logic       temp_high,
  input  logic       tank_low,
  input  logic       tank_full,
  output logic       sel_mode,
  output logic       valve_en,
  output logic       fill_pump,
  output logic       busy,
  output logic       alarm,
  output logic [2:0] state_o
);

  logic [4:0] raw_sens;
  logic [4:0] deb_sens;
  logic [1:0] umid_deb;
  logic       temp_high_deb, tank_low_deb, tank_full_deb, fault_cond;

  assign raw_sens = {tank_full, tank_low, temp_high, umid};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_deb
      sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk  (clk),
        .rst  (rst),
        .d_in (raw_sens[gi]),
        .d_out(deb_sens[gi])
      );
    end
  endgenerate

  assign umid_deb      = deb_sens[1:0];
  assign temp_high_deb = deb_sens[2];
  assign tank_low_deb  = deb_sens[3];
  assign tank_full_deb = deb_sens[4];
  assign fault_cond    = tank_low_deb & tank_full_deb;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             sel_mode_q, sel_mode_d;
  logic             timed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      sel_mode_q <= MODE_DRIP;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      sel_mode_q <= sel_mode_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_mode_d = sel_mode_q;
    case (state_q)
      ST_IDLE: begin
        if (fault_cond) begin
          state_d = ST_FAULT;
        end else if (tank_low_deb) begin
          state_d = ST_FILL;
        end else if (umid_deb <= UMID_DRY) begin
          if (umid_deb == UMID_VDRY && !temp_high_deb) begin
            state_d    = ST_SPRAY;
            sel_mode_d = MODE_SPRAY;
          end else begin
            state_d    = ST_DRIP;
            sel_mode_d = MODE_DRIP;
          end
        end
      end
      ST_DRIP: begin
        if (fault_cond)                                              state_d = ST_FAULT;
        else if (tank_low_deb)                                       state_d = ST_FILL;
        else if (umid_deb == UMID_WET ||
                 timer_q == CNT_W'(DRIP_CYCLES - 1))                 state_d = ST_COOL;
      end
      ST_SPRAY: begin
        if (fault_cond)                                              state_d = ST_FAULT;
        else if (tank_low_deb)                                       state_d = ST_FILL;
        else if (umid_deb == UMID_WET ||
                 timer_q == CNT_W'(SPRAY_CYCLES - 1))                state_d = ST_COOL;
      end
      ST_COOL: begin
        if (fault_cond)                                              state_d = ST_FAULT;
        else if (timer_q == CNT_W'(COOL_CYCLES - 1))                 state_d = ST_IDLE;
      end
      ST_FILL: begin
        if (fault_cond)                                              state_d = ST_FAULT;
        else if (tank_full_deb)                                      state_d = ST_IDLE;
        else if (timer_q == CNT_W'(FILL_MAX - 1))                    state_d = ST_FAULT;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Timer restarts on every state change, so each timed state measures its own dwell.
  assign timed   = (state_q == ST_DRIP) || (state_q == ST_SPRAY) ||
                   (state_q == ST_COOL) || (state_q == ST_FILL);
  assign timer_d = (state_d != state_q) ? '0 :
                   (timed ? timer_q + CNT_W'(1) : timer_q);

  assign sel_mode  = sel_mode_q;
  assign valve_en  = (state_q == ST_DRIP) || (state_q == ST_SPRAY);
  assign fill_pump = (state_q == ST_FILL);
  assign busy      = (state_q != ST_IDLE);
  assign alarm     = (state_q == ST_FAULT);
  assign state_o   = state_q;

endmodule
